// File: rtl/hazard_pkg.sv
// Shared widths and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int RW_DEF      = 5;
    localparam int LW_DEF      = 2;
    localparam int MAX_LAT_DEF = 3;

    typedef logic [RW_DEF-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/hazard_sb_cnt.sv
// One scoreboard entry: countdown of cycles until a pending write is usable.
import hazard_pkg::*;

module hazard_sb_cnt #(
    parameter int LW      = LW_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic          nz
);

    localparam logic [LW-1:0] MAXV = LW'(MAX_LAT);

    logic [LW-1:0] cnt;
    logic [LW-1:0] lat_c;

    assign lat_c = (lat > MAXV) ? MAXV : lat;
    assign nz    = (cnt != '0);

    // a new issue replaces whatever is left of the older write
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat_c;
        end else if (nz) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage RAW stall, redirect flush bubbles and run-limit counters.
import hazard_pkg::*;

module hazard_ctl #(
    parameter int NREG      = 32,
    parameter int RW        = RW_DEF,
    parameter int MAX_LAT   = MAX_LAT_DEF,
    parameter int LW        = LW_DEF,
    parameter int FLUSH_CYC = 2,
    parameter int RUN_LIMIT = 16,
    parameter int CNTW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rs,
    input  logic [RW-1:0]   issue_rt,
    input  logic            issue_uses_rt,
    input  logic            issue_wr,
    input  logic [RW-1:0]   issue_dst,
    input  logic [LW-1:0]   issue_lat,
    input  logic            redirect,
    output logic            stall,
    output logic            flush,
    output logic            busy,
    output logic [CNTW-1:0] stall_events,
    output logic            done
);

    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [FW-1:0]   FLUSH_V = FW'(FLUSH_CYC);
    localparam logic [CNTW-1:0] LIMIT   = CNTW'(RUN_LIMIT);

    logic [NREG-1:0] nz;
    logic [FW-1:0]   fcnt;
    logic [CNTW-1:0] cyc;
    logic [CNTW-1:0] cyc_nxt;
    logic            hit;
    logic            accept;
    logic            wr_en;

    assign nz[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_sb
            hazard_sb_cnt #(
                .LW      (LW),
                .MAX_LAT (MAX_LAT)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .load  (wr_en && (issue_dst == RW'(r))),
                .lat   (issue_lat),
                .nz    (nz[r])
            );
        end
    endgenerate

    assign flush  = (fcnt != '0);
    assign hit    = nz[issue_rs] | (issue_uses_rt & nz[issue_rt]);
    assign stall  = issue_valid & hit & ~flush;
    assign busy   = |nz;
    assign accept = issue_valid & ~stall & ~flush & ~redirect;
    assign wr_en  = accept & issue_wr & (issue_dst != RW'(ZERO_REG));

    // reload on every redirect so back-to-back redirects extend the bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt <= '0;
        end else if (redirect) begin
            fcnt <= FLUSH_V;
        end else if (flush) begin
            fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_events <= '0;
        end else if (stall && (stall_events != '1)) begin
            stall_events <= stall_events + 1'b1;
        end
    end

    assign cyc_nxt = (cyc == '1) ? cyc : cyc + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc  <= '0;
            done <= 1'b0;
        end else begin
            cyc  <= cyc_nxt;
            done <= done | (cyc_nxt > LIMIT);
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed self-checking bench for hazard_ctl.
module tb_hazard_ctl;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_uses_rt;
    logic        issue_wr;
    logic [4:0]  issue_dst;
    logic [1:0]  issue_lat;
    logic        redirect;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [15:0] stall_events;
    logic        done;

    int checks = 0;
    int errors = 0;

    hazard_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rt (issue_uses_rt),
        .issue_wr      (issue_wr),
        .issue_dst     (issue_dst),
        .issue_lat     (issue_lat),
        .redirect      (redirect),
        .stall         (stall),
        .flush         (flush),
        .busy          (busy),
        .stall_events  (stall_events),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt,
                         input logic wr, input logic [4:0] dst,
                         input logic [1:0] lat, input logic redir);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rt      = rt;
        issue_uses_rt = urt;
        issue_wr      = wr;
        issue_dst     = dst;
        issue_lat     = lat;
        redirect      = redir;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_events", 32'(stall_events), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // load-use on r3, lat=2
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 2'd2, 1'b0);
        chk("lu_issue_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("lu_busy", 32'(busy), 32'd1);
        chk("lu_stall1", 32'(stall), 32'd1);
        tick();
        chk("lu_stall2", 32'(stall), 32'd1);
        tick();
        chk("lu_stall3", 32'(stall), 32'd0);
        chk("lu_busy_off", 32'(busy), 32'd0);
        chk("lu_events", 32'(stall_events), 32'd2);
        tick();
        idle();

        // writes to r0 never pend
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 2'd3, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("r0_busy", 32'(busy), 32'd0);
        chk("r0_stall", 32'(stall), 32'd0);
        tick();

        // r5 pending, read only through an unused rt
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd3, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("imm_rt_stall", 32'(stall), 32'd0);
        drive(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("rt_used_stall", 32'(stall), 32'd1);
        idle();
        tick();
        tick();
        tick();
        chk("r5_drained", 32'(busy), 32'd0);

        // redirect while decode is stalled on r4
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 2'd3, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("rd_pre_stall", 32'(stall), 32'd1);
        tick();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
        tick();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("rd_flush1", 32'(flush), 32'd1);
        chk("rd_stall_f1", 32'(stall), 32'd0);
        chk("rd_busy_f1", 32'(busy), 32'd1);
        tick();
        chk("rd_flush2", 32'(flush), 32'd1);
        chk("rd_busy_f2", 32'(busy), 32'd0);
        tick();
        chk("rd_flush_end", 32'(flush), 32'd0);
        chk("rd_stall_end", 32'(stall), 32'd0);
        idle();
        tick();

        // redirect reload with an issue to r6 held through the window
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 2'd3, 1'b1);
        tick();
        chk("rl_flush1", 32'(flush), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 2'd3, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 2'd3, 1'b0);
        chk("rl_flush2", 32'(flush), 32'd1);
        chk("rl_busy2", 32'(busy), 32'd0);
        tick();
        chk("rl_flush3", 32'(flush), 32'd1);
        chk("rl_busy3", 32'(busy), 32'd0);
        idle();
        tick();
        chk("rl_flush_end", 32'(flush), 32'd0);
        chk("rl_busy_end", 32'(busy), 32'd0);

        // add r1,r1 with lat=1
        drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 2'd1, 1'b0);
        chk("self_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("self_rd_stall", 32'(stall), 32'd1);
        tick();
        chk("self_rd_go", 32'(stall), 32'd0);
        tick();
        idle();

        // r2 written with lat=3 then lat=0
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 2'd3, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 2'd0, 1'b0);
        chk("b2b_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_rd_stall", 32'(stall), 32'd0);
        tick();
        idle();

        // reset with r7 pending and one flush bubble left
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 2'd3, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
        tick();
        idle();
        tick();
        chk("pre_rst_flush", 32'(flush), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_done", 32'(done), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_flush", 32'(flush), 32'd0);
        chk("post_rst_events", 32'(stall_events), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        for (int i = 1; i <= 16; i++) tick();
        chk("done_16", 32'(done), 32'd0);
        tick();
        chk("done_17", 32'(done), 32'd1);
        tick();
        tick();
        tick();
        chk("done_held", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
